// File: rtl/serial_sample_fifo.sv
// serial_sample_fifo: deserialises MSB-first words from the Pi serial link,
// buffers them in a circular FIFO and hands one channel-tagged word to the
// downstream consumer per ready request. Single clock domain; rpi_clk, serial
// and ready are sampled as asynchronous data.
module serial_sample_fifo #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned LOW_WATER   = 16,
    parameter int unsigned HIGH_WATER  = 48,
    parameter int unsigned IDLE_CYCLES = 1024,
    localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int unsigned LW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rpi_clk,
    input  logic             serial,
    input  logic             enable,
    input  logic             ready,
    output logic             rpi_interrupt,
    output logic [WIDTH-1:0] data,
    output logic [CW-1:0]    channel,
    output logic             data_valid,
    output logic [LW-1:0]    level,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned BW = $clog2(WIDTH);
    localparam int unsigned IW = $clog2(IDLE_CYCLES + 1);

    logic [2:0]       rpi_sync_q, rpi_sync_d;
    logic [1:0]       ser_sync_q, ser_sync_d;
    logic [2:0]       rdy_sync_q, rdy_sync_d;
    logic [WIDTH-2:0] shift_q, shift_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [IW-1:0]    idle_cnt_q, idle_cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             push_q, push_d;
    logic             pop_q, pop_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [CW-1:0]    chan_cnt_q, chan_cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    channel_q, channel_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             irq_q, irq_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             rpi_edge;
    logic [WIDTH-1:0] shift_next;
    logic             empty, full, do_pop, do_push;

    // serial is delayed exactly like rpi_clk so the bit lines up with its edge
    assign rpi_edge   = rpi_sync_q[1] & ~rpi_sync_q[2];
    assign shift_next = {shift_q, ser_sync_q[1]};
    assign empty      = (level_q == '0);
    assign full       = (level_q == LW'(DEPTH));
    assign do_pop     = pop_q & ~empty;
    // a pop in the same cycle frees a slot, so a push at full still succeeds
    assign do_push    = push_q & (~full | do_pop);

    // Synchronisers, edge detection and the deserialiser with idle realignment
    always_comb begin
        rpi_sync_d = {rpi_sync_q[1:0], rpi_clk};
        ser_sync_d = {ser_sync_q[0], serial};
        rdy_sync_d = {rdy_sync_q[1:0], ready};
        pop_d      = rdy_sync_q[1] & ~rdy_sync_q[2];
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        word_d     = word_q;
        push_d     = 1'b0;
        idle_cnt_d = idle_cnt_q;
        if (rpi_edge) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != IW'(IDLE_CYCLES)) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
        if (!enable) begin
            shift_d   = '0;
            bit_cnt_d = '0;
        end else if (rpi_edge) begin
            if (bit_cnt_q == BW'(WIDTH - 1)) begin
                word_d    = shift_next;
                push_d    = 1'b1;
                shift_d   = '0;
                bit_cnt_d = '0;
            end else begin
                shift_d   = shift_next[WIDTH-2:0];
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end else if (idle_cnt_q == IW'(IDLE_CYCLES) && bit_cnt_q != '0) begin
            shift_d   = '0;
            bit_cnt_d = '0;
        end
    end

    // FIFO pointers, level, pop output register, sticky flags and interrupt
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        chan_cnt_d = chan_cnt_q;
        data_d     = data_q;
        channel_d  = channel_q;
        valid_d    = 1'b0;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        level_d    = level_q;
        irq_d      = irq_q;
        if (do_pop) begin
            data_d     = mem_q[rd_ptr_q];
            channel_d  = chan_cnt_q;
            chan_cnt_d = (chan_cnt_q == CW'(CHANNELS - 1)) ? '0 : chan_cnt_q + 1'b1;
            rd_ptr_d   = rd_ptr_q + 1'b1;
            valid_d    = 1'b1;
        end
        if (pop_q && empty) unf_d = 1'b1;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (push_q && !do_push) ovf_d = 1'b1;
        if (do_push && !do_pop) level_d = level_q + 1'b1;
        if (!do_push && do_pop) level_d = level_q - 1'b1;
        if (level_d <= LW'(LOW_WATER)) begin
            irq_d = 1'b1;
        end else if (level_d >= LW'(HIGH_WATER)) begin
            irq_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rpi_sync_q <= '0;
            ser_sync_q <= '0;
            rdy_sync_q <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            idle_cnt_q <= '0;
            word_q     <= '0;
            push_q     <= 1'b0;
            pop_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            chan_cnt_q <= '0;
            data_q     <= '0;
            channel_q  <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            irq_q      <= 1'b1;
        end else begin
            rpi_sync_q <= rpi_sync_d;
            ser_sync_q <= ser_sync_d;
            rdy_sync_q <= rdy_sync_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            word_q     <= word_d;
            push_q     <= push_d;
            pop_q      <= pop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            chan_cnt_q <= chan_cnt_d;
            data_q     <= data_d;
            channel_q  <= channel_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            irq_q      <= irq_d;
        end
    end

    // Storage array; contents are logically discarded by the pointer reset
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= word_q;
    end

    assign rpi_interrupt = irq_q;
    assign data          = data_q;
    assign channel       = channel_q;
    assign data_valid    = valid_q;
    assign level         = level_q;
    assign overflow      = ovf_q;
    assign underflow     = unf_q;

endmodule

// File: tb/tb_serial_sample_fifo.sv
// Directed bench for serial_sample_fifo with default parameters.
module tb_serial_sample_fifo;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rpi_clk = 1'b0;
    logic        serial = 1'b0;
    logic        enable = 1'b1;
    logic        ready = 1'b0;
    logic        rpi_interrupt;
    logic [15:0] data;
    logic [0:0]  channel;
    logic        data_valid;
    logic [6:0]  level;
    logic        overflow;
    logic        underflow;

    int errors = 0;
    int checks = 0;

    logic [15:0] q_data[$];
    logic [0:0]  q_ch[$];

    typedef struct {
        logic [15:0] word;
        logic [15:0] exp_data;
        logic [0:0]  exp_ch;
        logic [6:0]  exp_level;
    } vec_t;
    vec_t vecs[4];

    serial_sample_fifo dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rpi_clk      (rpi_clk),
        .serial       (serial),
        .enable       (enable),
        .ready        (ready),
        .rpi_interrupt(rpi_interrupt),
        .data         (data),
        .channel      (channel),
        .data_valid   (data_valid),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Record every popped word, sampled on the falling edge
    always @(negedge clk) begin
        if (data_valid) begin
            q_data.push_back(data);
            q_ch.push_back(channel);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        rpi_clk = 1'b0;
        ready   = 1'b0;
        enable  = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        q_data.delete();
        q_ch.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        serial  = b;
        rpi_clk = 1'b1;
        repeat (2) @(negedge clk);
        rpi_clk = 1'b0;
        repeat (1) @(negedge clk);
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) send_bit(w[i]);
        repeat (6) @(negedge clk);
    endtask

    task automatic pop();
        @(negedge clk);
        ready = 1'b1;
        repeat (2) @(negedge clk);
        ready = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // Pop one word and compare it against the expected word/channel
    task automatic pop_check(input string name, input logic [15:0] exp_d, input logic [0:0] exp_c);
        int n;
        n = q_data.size();
        pop();
        check({name, " pulses"}, q_data.size() - n, 1);
        if (q_data.size() > n) begin
            check({name, " data"}, q_data[$], exp_d);
            check({name, " channel"}, q_ch[$], exp_c);
        end
    endtask

    initial begin
        logic [15:0] w;
        vecs[0] = '{word: 16'hA5C3, exp_data: 16'hA5C3, exp_ch: 1'b1, exp_level: 7'd1};
        vecs[1] = '{word: 16'h0001, exp_data: 16'h0001, exp_ch: 1'b0, exp_level: 7'd1};
        vecs[2] = '{word: 16'h8000, exp_data: 16'h8000, exp_ch: 1'b1, exp_level: 7'd1};
        vecs[3] = '{word: 16'hFFFF, exp_data: 16'hFFFF, exp_ch: 1'b0, exp_level: 7'd1};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst data", data, 0);
        check("rst channel", channel, 0);
        check("rst valid", data_valid, 0);
        check("rst level", level, 0);
        check("rst overflow", overflow, 0);
        check("rst underflow", underflow, 0);
        check("rst irq", rpi_interrupt, 1);
        do_reset();

        // Single word round trip
        send_word(16'h01F4);
        check("single level1", level, 1);
        pop_check("single", 16'h01F4, 1'b0);
        check("single level0", level, 0);
        check("single irq", rpi_interrupt, 1);

        // Table: push then pop, channel keeps alternating
        foreach (vecs[i]) begin
            send_word(vecs[i].word);
            check($sformatf("vec%0d level", i), level, vecs[i].exp_level);
            pop_check($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_ch);
        end

        // Watermark hysteresis
        do_reset();
        for (int i = 0; i < 47; i++) send_word(16'(i));
        check("wm irq at 47", rpi_interrupt, 1);
        send_word(16'd47);
        check("wm level 48", level, 48);
        check("wm irq at 48", rpi_interrupt, 0);
        for (int i = 0; i < 31; i++) pop_check($sformatf("wm pop%0d", i), 16'(i), 1'(i));
        check("wm level 17", level, 17);
        check("wm irq at 17", rpi_interrupt, 0);
        pop_check("wm pop31", 16'd31, 1'b1);
        check("wm level 16", level, 16);
        check("wm irq at 16", rpi_interrupt, 1);

        // Overflow: 65th word dropped
        do_reset();
        for (int i = 0; i < 64; i++) send_word(16'(i * 3 + 5));
        check("ovf level 64", level, 64);
        check("ovf pre flag", overflow, 0);
        send_word(16'hBEEF);
        check("ovf flag", overflow, 1);
        check("ovf level still 64", level, 64);
        for (int i = 0; i < 64; i++) pop_check($sformatf("ovf pop%0d", i), 16'(i * 3 + 5), 1'(i));
        check("ovf drained", level, 0);
        check("ovf no extra", q_data.size(), 64);

        // Underflow on empty
        do_reset();
        pop();
        check("unf flag", underflow, 1);
        check("unf data", data, 0);
        check("unf channel", channel, 0);
        check("unf no valid", q_data.size(), 0);
        send_word(16'h5A5A);
        pop_check("unf after", 16'h5A5A, 1'b0);

        // Idle realignment after a 7-bit partial word
        do_reset();
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        repeat (1040) @(negedge clk);
        send_word(16'h1234);
        check("idle level", level, 1);
        pop_check("idle", 16'h1234, 1'b0);

        // enable low for one cycle discards the partial word
        do_reset();
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        send_word(16'h1234);
        check("en level", level, 1);
        pop_check("en", 16'h1234, 1'b0);

        // Push and pop in the same cycle at full
        do_reset();
        for (int i = 0; i < 64; i++) send_word(16'h0100 + 16'(i));
        w = 16'hCAFE;
        for (int i = 15; i >= 1; i--) send_bit(w[i]);
        @(negedge clk);
        serial  = w[0];
        rpi_clk = 1'b1;
        ready   = 1'b1;
        repeat (2) @(negedge clk);
        rpi_clk = 1'b0;
        ready   = 1'b0;
        repeat (8) @(negedge clk);
        check("coin level", level, 64);
        check("coin overflow", overflow, 0);
        check("coin pulses", q_data.size(), 1);
        if (q_data.size() > 0) check("coin data", q_data[0], 16'h0100);
        for (int i = 1; i < 64; i++) pop_check($sformatf("coin pop%0d", i), 16'h0100 + 16'(i), 1'(i));
        pop_check("coin last", 16'hCAFE, 1'b0);
        check("coin drained", level, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
